dp16k_fifo_ctrl: RTL

- Synchronous FIFO controller that drives one dual-port 16k block RAM (8- or 9-bit wrapper, single clock).
- Port A of the RAM is the write side; port B is the read side.
- The controller hides the RAM's one-cycle read latency behind a 2-entry output stage, giving first-word-fall-through reads at 1 word/cycle.
- Used for SNES audio/DMA/line buffers between producer and consumer logic in the same clock domain.

---
 rtl/dp16k_fifo_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dp16k_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// dp16k_fifo_ctrl
//
// Single-clock FIFO controller for an external dual-port 16k block RAM
// (8- or 9-bit wrapper). Port A of the RAM is the write side and port B is
// the read side. A 2-entry output stage (head + skid) hides the RAM's
// one-cycle read latency. Reads are first-word-fall-through and can run at
// 1 word/cycle.
//
// Ports:
//   clock, reset           sole clock; synchronous active-high reset
//   wr_en, wr_data         push request and push word
//   full                   RAM occupancy == DEPTH (a push is dropped)
//   rd_en                  pop request; acknowledges the current rd_data
//   rd_data, empty         head word; valid while empty == 0
//   count                  words held in RAM, in flight and in the stage
//   overflow, underflow    sticky error flags
//   ram_address_a/_data_a/_wren_a/_enable_a   RAM write port
//   ram_address_b/_enable_b, ram_q_b          RAM read port (1-cycle latency)
// ---------------------------------------------------------------------------
module dp16k_fifo_ctrl #(
  parameter int addr_width = 11,
  parameter int data_width = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [data_width-1:0] rd_data,
  output logic                  empty,
  output logic [addr_width+1:0] count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [addr_width-1:0] ram_address_a,
  output logic [data_width-1:0] ram_data_a,
  output logic                  ram_wren_a,
  output logic                  ram_enable_a,
  output logic [addr_width-1:0] ram_address_b,
  output logic                  ram_enable_b,
  input  logic [data_width-1:0] ram_q_b
);

  // Pointers carry one extra wrap bit so full and RAM-empty are distinct.
  logic [addr_width:0]   wr_ptr_q, wr_ptr_d;
  logic [addr_width:0]   rd_ptr_q, rd_ptr_d;
  logic                  inflight_q, inflight_d;
  logic [data_width-1:0] head_q, head_d;
  logic [data_width-1:0] skid_q, skid_d;
  logic [1:0]            stage_occ_q, stage_occ_d;
  logic [addr_width+1:0] count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic       ram_empty;
  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] pending;
  logic [1:0] occ_after_pop;

  // Status is derived from registered pointers only, so a word written this
  // cycle is never visible to the read side until the next cycle. That keeps
  // port B off the address port A is writing.
  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[addr_width] != rd_ptr_q[addr_width]) &&
                     (wr_ptr_q[addr_width-1:0] == rd_ptr_q[addr_width-1:0]);
  assign empty     = (stage_occ_q == 2'd0);

  assign push = wr_en && !full && !reset;
  assign pop  = rd_en && !empty && !reset;

  // Slots that will be committed next cycle: the current stage, plus the
  // word landing from the RAM, minus the word leaving through a pop. A new
  // read may only be issued if that leaves room for its data.
  assign pending = {1'b0, stage_occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue   = !ram_empty && (pending < 3'd2) && !reset;

  assign occ_after_pop = stage_occ_q - {1'b0, pop};

  // NOTE: every variable gets its default first so that no path through
  // this block leaves a value unassigned; otherwise a latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    inflight_d  = issue;
    head_d      = head_q;
    skid_d      = skid_q;
    stage_occ_d = occ_after_pop + {1'b0, inflight_q};
    count_d     = count_q + {{(addr_width+1){1'b0}}, push}
                          - {{(addr_width+1){1'b0}}, pop};
    overflow_d  = overflow_q  | (wr_en && full);
    underflow_d = underflow_q | (rd_en && empty);

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (issue) rd_ptr_d = rd_ptr_q + 1'b1;

    // The pop is applied first so the arriving word lands in the first slot
    // that is free after the pop.
    if (pop) head_d = skid_q;
    if (inflight_q) begin
      if (occ_after_pop == 2'd0) head_d = ram_q_b;
      else                       skid_d = ram_q_b;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: only the controller's own registers are reset. The RAM array
      // behind it is not cleared and needs no clearing, because the pointers
      // define which words are valid. Resetting inflight_q discards any word
      // still on ram_q_b.
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= 1'b0;
      head_q      <= '0;
      skid_q      <= '0;
      stage_occ_q <= 2'd0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      stage_occ_q <= stage_occ_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_data       = head_q;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;
  assign ram_address_a = wr_ptr_q[addr_width-1:0];
  assign ram_data_a    = wr_data;
  assign ram_wren_a    = push;
  assign ram_enable_a  = 1'b1;
  assign ram_address_b = rd_ptr_q[addr_width-1:0];
  assign ram_enable_b  = issue;

endmodule
